cnu_c2v_serializer_8: RTL and testbench

CNU_C2V_SERIALIZER_8 -- requirements
Module: cnu_c2v_serializer_8

---
 rtl/cnu_c2v_serializer_8.sv | 96 +++++++++
 tb/tb_cnu_c2v_serializer_8.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/cnu_c2v_serializer_8.sv
// Check-node-to-variable message serializer: latches one min-finder result and
// emits the eight C2V sign-magnitude messages in edge order, with a ready/valid handshake on each side.
module cnu_c2v_serializer_8 #(
    parameter int CN_DEGREE = 8,
    parameter int QUAN_SIZE = 4
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [QUAN_SIZE-1:0] m1,
    input  logic [QUAN_SIZE-1:0] m2,
    input  logic [2:0]           min_index,
    input  logic [CN_DEGREE-1:0] sign_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [QUAN_SIZE:0]   c2v_msg,
    output logic [2:0]           c2v_edge,
    output logic                 c2v_last
);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t               state;
    logic [2:0]           cnt;
    logic [2:0]           nxt_edge;
    logic [QUAN_SIZE-1:0] m1_q;
    logic [QUAN_SIZE-1:0] m2_q;
    logic [2:0]           idx_q;
    logic [CN_DEGREE-1:0] sign_q;
    logic                 par_q;
    logic                 advance;
    logic                 last_hs;
    logic                 accept;

    // Edge k gets the extrinsic minimum; zero magnitude is always emitted as +0.
    function automatic logic [QUAN_SIZE:0] beat(
        input logic [QUAN_SIZE-1:0] a,
        input logic [QUAN_SIZE-1:0] b,
        input logic [2:0]           idx,
        input logic [CN_DEGREE-1:0] s,
        input logic                 p,
        input logic [2:0]           e
    );
        logic [QUAN_SIZE-1:0] mag;
        logic                 sg;
        mag = (e == idx) ? b : a;
        sg  = (mag != '0) && (p ^ s[e]);
        return {sg, mag};
    endfunction

    assign advance  = out_valid && out_ready;
    assign last_hs  = advance && c2v_last;
    assign in_ready = !rst && ((state == IDLE) || last_hs);
    assign accept   = in_valid && in_ready;
    assign nxt_edge = cnt + 3'd1;
    assign c2v_edge = cnt;

    // Output registers are loaded one beat ahead so the next beat is ready on the following edge.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            m1_q      <= '0;
            m2_q      <= '0;
            idx_q     <= '0;
            sign_q    <= '0;
            par_q     <= 1'b0;
            out_valid <= 1'b0;
            c2v_msg   <= '0;
            c2v_last  <= 1'b0;
        end else if (accept) begin
            state     <= EMIT;
            cnt       <= '0;
            m1_q      <= m1;
            m2_q      <= m2;
            idx_q     <= min_index;
            sign_q    <= sign_in;
            par_q     <= ^sign_in;
            out_valid <= 1'b1;
            c2v_msg   <= beat(m1, m2, min_index, sign_in, ^sign_in, 3'd0);
            c2v_last  <= 1'b0;
        end else if (last_hs) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            c2v_msg   <= '0;
            c2v_last  <= 1'b0;
        end else if (advance) begin
            cnt       <= nxt_edge;
            c2v_msg   <= beat(m1_q, m2_q, idx_q, sign_q, par_q, nxt_edge);
            c2v_last  <= (nxt_edge == 3'd7);
        end
    end

endmodule

// File: tb/tb_cnu_c2v_serializer_8.sv
// Randomized and directed bench for cnu_c2v_serializer_8 against a queue-of-beats reference model.
module tb_cnu_c2v_serializer_8;

    logic       sys_clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] m1 = '0;
    logic [3:0] m2 = '0;
    logic [2:0] min_index = '0;
    logic [7:0] sign_in = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [4:0] c2v_msg;
    logic [2:0] c2v_edge;
    logic       c2v_last;

    typedef struct packed {
        logic [4:0] msg;
        logic [2:0] edge_n;
        logic       last;
    } beat_t;

    beat_t q[$];
    int    errors = 0;
    int    checks = 0;
    logic  after_rst = 1'b0;

    cnu_c2v_serializer_8 #(.CN_DEGREE(8), .QUAN_SIZE(4)) dut (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .m1        (m1),
        .m2        (m2),
        .min_index (min_index),
        .sign_in   (sign_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c2v_msg   (c2v_msg),
        .c2v_edge  (c2v_edge),
        .c2v_last  (c2v_last)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Edge e is negative when an odd number of the other seven inputs are negative.
    task automatic push_frame(input logic [3:0] a, input logic [3:0] b,
                              input logic [2:0] idx, input logic [7:0] s);
        for (int e = 0; e < 8; e++) begin
            beat_t bt;
            logic [3:0] mag;
            int others;
            mag    = (e == int'(idx)) ? b : a;
            others = $countones(s) - int'(s[e]);
            bt.msg    = {(mag != 0) && (others % 2 == 1), mag};
            bt.edge_n = 3'(e);
            bt.last   = (e == 7);
            q.push_back(bt);
        end
        after_rst = 1'b0;
    endtask

    task automatic step();
        logic exp_ready;
        logic take;
        @(negedge sys_clk);
        exp_ready = !rst && (q.size() == 0 || (q.size() == 1 && out_ready));
        chk("in_ready", 8'(in_ready), 8'(exp_ready));
        chk("out_valid", 8'(out_valid), 8'(q.size() != 0));
        if (q.size() != 0) begin
            chk("c2v_msg", 8'(c2v_msg), 8'(q[0].msg));
            chk("c2v_edge", 8'(c2v_edge), 8'(q[0].edge_n));
            chk("c2v_last", 8'(c2v_last), 8'(q[0].last));
        end else if (after_rst) begin
            chk("rst_msg", 8'(c2v_msg), 8'h00);
            chk("rst_edge", 8'(c2v_edge), 8'h00);
            chk("rst_last", 8'(c2v_last), 8'h00);
        end
        take = in_valid && exp_ready;
        @(posedge sys_clk);
        if (rst) begin
            q.delete();
            after_rst = 1'b1;
        end else begin
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (take) push_frame(m1, m2, min_index, sign_in);
        end
        #1;
    endtask

    task automatic offer(input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] idx, input logic [7:0] s);
        m1 = a; m2 = b; min_index = idx; sign_in = s;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        chk("drain_timeout", 8'(q.size() != 0), 8'h00);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
        step();
        rst = 1'b0;
        step();

        // Single frame, out_ready held high
        offer(4'd2, 4'd5, 3'd3, 8'b0000_0101);
        drain(20);
        step();

        // Back-pressure with out_ready pattern 1,0,0,1
        offer(4'd2, 4'd5, 3'd3, 8'b0000_0101);
        n = 0;
        while (q.size() != 0 && n < 60) begin
            out_ready = (n % 4 == 0) || (n % 4 == 3);
            step();
            n++;
        end
        chk("bp_timeout", 8'(q.size() != 0), 8'h00);
        out_ready = 1'b1;
        step();

        // Back-to-back frames with no idle cycle
        offer(4'd6, 4'd9, 3'd2, 8'h3C);
        n = 0;
        while (q.size() > 1 && n < 20) begin
            step();
            n++;
        end
        offer(4'd1, 4'd3, 3'd7, 8'hFF);
        drain(20);

        // Zero minimum magnitude
        offer(4'd0, 4'd4, 3'd0, 8'h01);
        drain(20);

        // Input pulse mid-frame must be ignored
        offer(4'd7, 4'd8, 3'd5, 8'h92);
        step();
        step();
        offer(4'd15, 4'd15, 3'd0, 8'h00);
        drain(20);

        // Reset after the edge-3 handshake
        offer(4'd3, 4'd6, 3'd1, 8'h41);
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        offer(4'd2, 4'd5, 3'd3, 8'b0000_0101);
        drain(20);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            m1        = 4'($urandom);
            m2        = 4'($urandom);
            min_index = 3'($urandom);
            sign_in   = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            if (($urandom_range(0, 3) == 0)) m1 = 4'd0;
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
